hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the pipelined OTTER core; it supersedes single-cycle load-use detection.
//  - Keeps one pending-latency counter per architectural register.
//  - Stalls IF/ID when a decode-stage source is not yet forwardable.
//  - Inserts a bubble into ID/EX on a stall and flushes IF/ID and ID/EX on a taken branch/jump.
//  - Handles variable-latency producers (loads, mul/div) with no per-op logic in the pipeline.
// PARAMETERS
//  NUM_REGS    32  architectural registers; x0 is never pending
//  REG_ADDR_W  5   register address width; must satisfy 2**REG_ADDR_W == NUM_REGS
//  MAX_LAT     7   largest producer latency, in cycles until result is forwardable
//  LAT_W       3   counter width; must equal $clog2(MAX_LAT+1)
// PORTS
//  CLK           in   1           rising-edge clock
//  RST_N         in   1           asynchronous, active-low reset
//  ID_Valid      in   1           decode stage holds a real instruction
//  ID_RS1        in   REG_ADDR_W  source 1 address
//  ID_RS2        in   REG_ADDR_W  source 2 address
//  ID_RS1_Used   in   1           instruction reads RS1
//  ID_RS2_Used   in   1           instruction reads RS2
//  ID_RD         in   REG_ADDR_W  destination address
//  ID_RD_Wr      in   1           instruction writes RD
//  ID_Lat        in   LAT_W       extra cycles before RD is forwardable (0=ALU, 1=load, N=mul/div)
//  EX_BrTaken    in   1           taken branch/jump resolved in EX this cycle
//  PCWrite       out  1           PC may advance
//  IF_ID_Write   out  1           IF/ID register may load
//  select        out  1           1 = pass decoded controls into ID/EX; 0 = insert bubble
//  IF_ID_Flush   out  1           clear IF/ID
//  ID_EX_Flush   out  1           clear ID/EX
//  Pending       out  NUM_REGS    bit r = cnt[r]!=0; bit 0 is always 0
//  StallCnt      out  32          stall-cycle counter (see CONFIGURATION)
//  FlushCnt      out  32          flush-event counter (see CONFIGURATION)
// BEHAVIOUR
//  - State: cnt[r] (LAT_W bits) per register. Reset sets all cnt to 0 asynchronously.
//  - Hazard (comb) = ID_Valid & ((RS1_Used & RS1!=0 & cnt[RS1]!=0) | (RS2_Used & RS2!=0 & cnt[RS2]!=0)).
//  - stall = hazard & ~EX_BrTaken. A flush always overrides a stall.
//  - Outputs are combinational from registered cnt and current inputs:
//    - PCWrite = IF_ID_Write = select = ~stall.
//    - IF_ID_Flush = ID_EX_Flush = EX_BrTaken.
//  - Output values during reset / with ID_Valid=0: PCWrite=1, IF_ID_Write=1, select=1, flushes follow EX_BrTaken, Pending=0.
//  - Issue = ID_Valid & ~stall & ~EX_BrTaken & ID_RD_Wr & ID_RD!=0 & ID_Lat!=0.
//  - Per-edge update for each r:
//    - issue to r: cnt[r] <= max(ID_Lat, sat0(cnt[r]-1)). A WAW hazard keeps the longer latency.
//    - otherwise: cnt[r] <= sat0(cnt[r]-1).
//  - Timing example: a load (ID_Lat=1) followed by a dependent instruction gives exactly one bubble. ID_Lat=N gives N bubbles for an immediately dependent consumer.
//  - Consumer-vs-decrement ordering: the stall decision uses the pre-edge cnt. A source whose cnt is 1 still stalls that cycle and is clear the next cycle.
//  - A flushed or stalled instruction never writes the scoreboard. Entries already issued keep counting; older instructions are never flushed.
//  - ID_Lat > MAX_LAT is clamped to MAX_LAT. Issue to x0 is ignored.
//  - Reset asserted mid-operation clears all counters immediately. The first post-reset cycle sees no pending registers.
// CONFIGURATION
//  HAZ_STATS_EN
//   - Defined:
//     - StallCnt increments on every cycle with stall=1.
//     - FlushCnt increments on every cycle with EX_BrTaken=1.
//     - Both are 32-bit, saturating at 32'hFFFF_FFFF, and reset to 0.
//   - Undefined: StallCnt and FlushCnt are tied to 0 and no counter flops are built.
// TESTING
//  1. Reset.
//     - Stimulus: RST_N=0 with ID_Valid=1, RS1=5, RS1_Used=1.
//     - Required: PCWrite=1, select=1, Pending=0.
//  2. Load-use.
//     - Stimulus: issue RD=5, Lat=1; next cycle ID RS1=5.
//     - Required: exactly 1 cycle of PCWrite=IF_ID_Write=select=0, then 1.
//  3. Multi-cycle producer.
//     - Stimulus: issue RD=7, Lat=4; next cycle ID RS2=7.
//     - Required: 4 stall cycles; Pending[7] sequence 1,1,1,1,0.
//  4. Flush beats stall.
//     - Stimulus: hazard on RS1=5 and EX_BrTaken=1 in the same cycle.
//     - Required: PCWrite=1, IF_ID_Flush=ID_EX_Flush=1, no scoreboard write.
//  5. WAW and x0.
//     - Stimulus: issue RD=3, Lat=5, then RD=3, Lat=1; separately issue RD=0, Lat=3.
//     - Required: cnt[3]=4 after the second issue; Pending[0]=0.
//  6. Stats (HAZ_STATS_EN).
//     - Stimulus: scenario 3 followed by 2 branch flushes.
//     - Required: StallCnt=4, FlushCnt=2. With the macro undefined: both 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Purpose : per-register pending-latency scoreboard; stalls IF/ID on an unready source and flushes on taken branches.
// Latency : stall/flush outputs are combinational from registered counters; a counter update lands on the next edge.
// Backpr. : a stall holds PC and IF/ID and bubbles ID/EX; a flush (EX_BrTaken) always wins over a stall.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   ID_Valid                        decode stage holds a real instruction
//   ID_RS1/ID_RS2 (+_Used)          decode-stage source addresses and read enables
//   ID_RD, ID_RD_Wr, ID_Lat         destination, write enable, extra cycles until forwardable
//   EX_BrTaken                      taken branch/jump resolved in EX
//   PCWrite, IF_ID_Write, select    all equal ~stall
//   IF_ID_Flush, ID_EX_Flush        both equal EX_BrTaken
//   Pending                         bit r set while register r has a non-zero counter
//   StallCnt, FlushCnt              event counters, only built when HAZ_STATS_EN is defined
//
// Optional feature macro: HAZ_STATS_EN (saturating stall/flush event counters).

module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 7,
    parameter int LAT_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_RS1_Used,
    input  logic                  ID_RS2_Used,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  ID_RD_Wr,
    input  logic [LAT_W-1:0]      ID_Lat,
    input  logic                  EX_BrTaken,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  select,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic [NUM_REGS-1:0]   Pending,
    output logic [31:0]           StallCnt,
    output logic [31:0]           FlushCnt
);

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt [NUM_REGS];

    logic             rs1_haz;
    logic             rs2_haz;
    logic             hazard;
    logic             stall;
    logic             issue;
    logic [LAT_W-1:0] lat_eff;

    // Stall decision uses the pre-edge counter: a source at 1 still stalls this cycle.
    assign rs1_haz = ID_RS1_Used && (ID_RS1 != '0) && (cnt[ID_RS1] != '0);
    assign rs2_haz = ID_RS2_Used && (ID_RS2 != '0) && (cnt[ID_RS2] != '0);
    assign hazard  = ID_Valid && (rs1_haz || rs2_haz);
    assign stall   = hazard && !EX_BrTaken;

    assign PCWrite     = !stall;
    assign IF_ID_Write = !stall;
    assign select      = !stall;
    assign IF_ID_Flush = EX_BrTaken;
    assign ID_EX_Flush = EX_BrTaken;

    // Only an instruction that actually leaves decode may claim its destination.
    // Zero-latency producers are forwardable immediately and never need an entry.
    assign issue   = ID_Valid && !stall && !EX_BrTaken && ID_RD_Wr
                     && (ID_RD != '0) && (ID_Lat != '0);
    assign lat_eff = (ID_Lat > MAX_LAT_V) ? MAX_LAT_V : ID_Lat;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] == '0) ? '0 : cnt[r] - LAT_W'(1);
            // WAW: keep whichever producer finishes later.
            if (issue && (ID_RD == REG_ADDR_W'(r)) && (lat_eff > cnt_nxt[r])) begin
                cnt_nxt[r] = lat_eff;
            end
        end
        cnt_nxt[0] = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    always_comb begin
        Pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            Pending[r] = (cnt[r] != '0);
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (EX_BrTaken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : directed self-checking bench for hazard_scoreboard.
// Latency : inputs change 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpr. : stall/flush outputs are compared cycle by cycle against hand-computed values.

module tb_hazard_scoreboard;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ID_Valid;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic        ID_RS1_Used;
    logic        ID_RS2_Used;
    logic [4:0]  ID_RD;
    logic        ID_RD_Wr;
    logic [2:0]  ID_Lat;
    logic        EX_BrTaken;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        select;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic [31:0] Pending;
    logic [31:0] StallCnt;
    logic [31:0] FlushCnt;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ID_Valid    (ID_Valid),
        .ID_RS1      (ID_RS1),
        .ID_RS2      (ID_RS2),
        .ID_RS1_Used (ID_RS1_Used),
        .ID_RS2_Used (ID_RS2_Used),
        .ID_RD       (ID_RD),
        .ID_RD_Wr    (ID_RD_Wr),
        .ID_Lat      (ID_Lat),
        .EX_BrTaken  (EX_BrTaken),
        .PCWrite     (PCWrite),
        .IF_ID_Write (IF_ID_Write),
        .select      (select),
        .IF_ID_Flush (IF_ID_Flush),
        .ID_EX_Flush (ID_EX_Flush),
        .Pending     (Pending),
        .StallCnt    (StallCnt),
        .FlushCnt    (FlushCnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        ID_Valid    = 1'b0;
        ID_RS1      = '0;
        ID_RS2      = '0;
        ID_RS1_Used = 1'b0;
        ID_RS2_Used = 1'b0;
        ID_RD       = '0;
        ID_RD_Wr    = 1'b0;
        ID_Lat      = '0;
        EX_BrTaken  = 1'b0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic [2:0] lat);
        drive_idle();
        ID_Valid = 1'b1;
        ID_RD    = rd;
        ID_RD_Wr = 1'b1;
        ID_Lat   = lat;
    endtask

    task automatic drive_use(input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2);
        drive_idle();
        ID_Valid    = 1'b1;
        ID_RS1      = rs1;
        ID_RS1_Used = u1;
        ID_RS2      = rs2;
        ID_RS2_Used = u2;
    endtask

    task automatic idle_cycles(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive_use(5'd5, 1'b1, 5'd0, 1'b0);
        #2;
        checks++;
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL reset_pcwrite got=%b exp=1", PCWrite); end
        checks++;
        if (select !== 1'b1) begin failures++; $display("FAIL reset_select got=%b exp=1", select); end
        checks++;
        if (IF_ID_Write !== 1'b1) begin failures++; $display("FAIL reset_ifid_write got=%b exp=1", IF_ID_Write); end
        checks++;
        if (Pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", Pending); end
        checks++;
        if (IF_ID_Flush !== 1'b0 || ID_EX_Flush !== 1'b0) begin
            failures++; $display("FAIL reset_flush got=%b%b exp=00", IF_ID_Flush, ID_EX_Flush);
        end
        checks++;
        if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
            failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", StallCnt, FlushCnt);
        end
        tick();
        RST_N = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_load_use();
        drive_issue(5'd5, 3'd1);
        tick();
        drive_use(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if ({PCWrite, IF_ID_Write, select} !== 3'b000) begin
            failures++; $display("FAIL loaduse_stall got=%b exp=000", {PCWrite, IF_ID_Write, select});
        end
        checks++;
        if (Pending[5] !== 1'b1) begin failures++; $display("FAIL loaduse_pend got=%b exp=1", Pending[5]); end
        tick();
        checks++;
        if ({PCWrite, IF_ID_Write, select} !== 3'b111) begin
            failures++; $display("FAIL loaduse_release got=%b exp=111", {PCWrite, IF_ID_Write, select});
        end
        checks++;
        if (Pending[5] !== 1'b0) begin failures++; $display("FAIL loaduse_clear got=%b exp=0", Pending[5]); end
        idle_cycles(2);
    endtask

    task automatic test_multi_cycle();
        logic exp_stall;
        drive_issue(5'd7, 3'd4);
        tick();
        // Stalled consumer also tries to write x10; it must not claim it while stalled.
        drive_use(5'd0, 1'b0, 5'd7, 1'b1);
        ID_RD_Wr = 1'b1;
        ID_RD    = 5'd10;
        ID_Lat   = 3'd3;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_stall = (k < 4);
            checks++;
            if (PCWrite !== !exp_stall) begin
                failures++; $display("FAIL multi_pcwrite[%0d] got=%b exp=%b", k, PCWrite, !exp_stall);
            end
            checks++;
            if (Pending[7] !== exp_stall) begin
                failures++; $display("FAIL multi_pend7[%0d] got=%b exp=%b", k, Pending[7], exp_stall);
            end
            checks++;
            if (Pending[10] !== 1'b0) begin
                failures++; $display("FAIL multi_stalled_write[%0d] got=%b exp=0", k, Pending[10]);
            end
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (Pending[10] !== 1'b1) begin failures++; $display("FAIL multi_issue10 got=%b exp=1", Pending[10]); end
        idle_cycles(8);
    endtask

    task automatic test_flush();
        drive_issue(5'd5, 3'd3);
        tick();
        drive_use(5'd5, 1'b1, 5'd0, 1'b0);
        ID_RD_Wr   = 1'b1;
        ID_RD      = 5'd9;
        ID_Lat     = 3'd2;
        EX_BrTaken = 1'b1;
        #1;
        checks++;
        if ({PCWrite, IF_ID_Write, select} !== 3'b111) begin
            failures++; $display("FAIL flush_nostall got=%b exp=111", {PCWrite, IF_ID_Write, select});
        end
        checks++;
        if ({IF_ID_Flush, ID_EX_Flush} !== 2'b11) begin
            failures++; $display("FAIL flush_out got=%b exp=11", {IF_ID_Flush, ID_EX_Flush});
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (Pending[9] !== 1'b0) begin failures++; $display("FAIL flush_nowrite got=%b exp=0", Pending[9]); end
        checks++;
        if (Pending[5] !== 1'b1 || PCWrite !== 1'b1) begin
            failures++; $display("FAIL invalid_nostall got=%b/%b exp=1/1", Pending[5], PCWrite);
        end
        drive_use(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (PCWrite !== 1'b0) begin failures++; $display("FAIL flush_older_kept got=%b exp=0", PCWrite); end
        idle_cycles(5);
    endtask

    task automatic test_waw_x0();
        logic exp_stall;
        drive_issue(5'd3, 3'd5);
        tick();
        drive_issue(5'd3, 3'd1);
        tick();
        // cnt[3] should now be 4: an immediate consumer sees exactly 4 stall cycles.
        drive_use(5'd3, 1'b1, 5'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_stall = (k < 4);
            checks++;
            if (PCWrite !== !exp_stall) begin
                failures++; $display("FAIL waw_stall[%0d] got=%b exp=%b", k, PCWrite, !exp_stall);
            end
            tick();
        end
        idle_cycles(6);
        drive_issue(5'd0, 3'd3);
        tick();
        drive_use(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        checks++;
        if (Pending !== 32'h0) begin failures++; $display("FAIL x0_pending got=%h exp=0", Pending); end
        checks++;
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL x0_nostall got=%b exp=1", PCWrite); end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        drive_issue(5'd6, 3'd7);
        tick();
        drive_idle();
        #1;
        checks++;
        if (Pending[6] !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", Pending[6]); end
        RST_N = 1'b0;
        #1;
        checks++;
        if (Pending !== 32'h0) begin failures++; $display("FAIL midrst_clear got=%h exp=0", Pending); end
        tick();
        RST_N = 1'b1;
        drive_use(5'd6, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL midrst_first got=%b exp=1", PCWrite); end
        idle_cycles(2);
    endtask

    task automatic test_stats();
        logic [31:0] exp_stalls;
        logic [31:0] exp_flushes;
`ifdef HAZ_STATS_EN
        exp_stalls  = 32'd4;
        exp_flushes = 32'd2;
`else
        exp_stalls  = 32'd0;
        exp_flushes = 32'd0;
`endif
        drive_idle();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        drive_issue(5'd7, 3'd4);
        tick();
        drive_use(5'd0, 1'b0, 5'd7, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        drive_idle();
        EX_BrTaken = 1'b1;
        tick();
        tick();
        drive_idle();
        #1;
        checks++;
        if (StallCnt !== exp_stalls) begin
            failures++; $display("FAIL stats_stall got=%0d exp=%0d", StallCnt, exp_stalls);
        end
        checks++;
        if (FlushCnt !== exp_flushes) begin
            failures++; $display("FAIL stats_flush got=%0d exp=%0d", FlushCnt, exp_flushes);
        end
    endtask

    initial begin
        drive_idle();
        RST_N = 1'b0;
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_flush();
        test_waw_x0();
        test_reset_mid();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
